// File: rtl/control_pad_encoder.sv
// control_pad_encoder: synchronizes and debounces 12 pad buttons, then turns each axis pair into step pulses.
// Auto-repeat timing (DELAY -> REPEAT) is built only when CTRL_PAD_AUTOREPEAT_EN is defined; otherwise one pulse per press.
module control_pad_encoder #(
  parameter int unsigned DEBOUNCE_CYC  = 500000,
  parameter int unsigned REPEAT_DELAY  = 5000000,
  parameter int unsigned REPEAT_PERIOD = 500000
) (
  input  logic        fclk,
  input  logic        rst,
  input  logic [11:0] btn_raw,
  output logic [11:0] controlPad,
  output logic [11:0] btn_db
);

  localparam logic [23:0] DB_LAST = 24'(DEBOUNCE_CYC - 1);

`ifdef CTRL_PAD_AUTOREPEAT_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } axis_state_t;

  localparam logic [23:0] RD_LAST = 24'(REPEAT_DELAY - 1);
  localparam logic [23:0] RP_LAST = 24'(REPEAT_PERIOD - 1);

  logic [23:0] r_rcnt     [6];
  logic [23:0] w_rcnt_nxt [6];
`else
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DELAY = 1'b1
  } axis_state_t;

  // Repeat timing parameters have no function without auto-repeat.
  logic [47:0] w_unused_rpt;
  assign w_unused_rpt = {24'(REPEAT_DELAY), 24'(REPEAT_PERIOD)};
`endif

  logic [11:0] r_sync1;
  logic [11:0] r_sync2;
  logic [11:0] r_btn_db;
  logic [23:0] r_dbcnt [12];

  axis_state_t r_state     [6];
  axis_state_t w_state_nxt [6];
  logic [1:0]  r_dir       [6];
  logic [1:0]  w_dir_nxt   [6];
  logic [1:0]  w_req       [6];
  logic [11:0] r_pad;
  logic [11:0] w_pad_nxt;

  // Two-flop synchronizer feeding per-bit debounce counters.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 12'h000;
      r_sync2  <= 12'h000;
      r_btn_db <= 12'h000;
      for (int i = 0; i < 12; i++) begin
        r_dbcnt[i] <= 24'd0;
      end
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 12; i++) begin
        if (r_sync2[i] == r_btn_db[i]) begin
          r_dbcnt[i] <= 24'd0;
        end else if (r_dbcnt[i] == DB_LAST) begin
          r_btn_db[i] <= ~r_btn_db[i];
          r_dbcnt[i]  <= 24'd0;
        end else begin
          r_dbcnt[i] <= r_dbcnt[i] + 24'd1;
        end
      end
    end
  end

  // Axis k owns debounced bits [2k+1:2k]; a direction counts only when exactly one bit is held.
  always_comb begin
    for (int k = 0; k < 6; k++) begin
      if (r_btn_db[2*k+1] ^ r_btn_db[2*k]) begin
        w_req[k] = r_btn_db[2*k +: 2];
      end else begin
        w_req[k] = 2'b00;
      end
    end
  end

  // Per-axis next state, latched direction and pulse for the registered pad output.
  always_comb begin
    w_pad_nxt = 12'h000;
    for (int k = 0; k < 6; k++) begin
      w_state_nxt[k] = r_state[k];
      w_dir_nxt[k]   = r_dir[k];
`ifdef CTRL_PAD_AUTOREPEAT_EN
      w_rcnt_nxt[k]  = r_rcnt[k];
`endif
    end
    for (int k = 0; k < 6; k++) begin
      case (r_state[k])
        S_IDLE: begin
          if (w_req[k] != 2'b00) begin
            w_pad_nxt[2*k +: 2] = w_req[k];
            w_dir_nxt[k]        = w_req[k];
            w_state_nxt[k]      = S_DELAY;
`ifdef CTRL_PAD_AUTOREPEAT_EN
            w_rcnt_nxt[k]       = 24'd0;
`endif
          end else begin
            w_state_nxt[k] = S_IDLE;
          end
        end
`ifdef CTRL_PAD_AUTOREPEAT_EN
        S_DELAY: begin
          if (w_req[k] != r_dir[k]) begin
            w_state_nxt[k] = S_IDLE;
          end else if (r_rcnt[k] == RD_LAST) begin
            w_pad_nxt[2*k +: 2] = r_dir[k];
            w_rcnt_nxt[k]       = 24'd0;
            w_state_nxt[k]      = S_REPEAT;
          end else begin
            w_rcnt_nxt[k] = r_rcnt[k] + 24'd1;
          end
        end
        S_REPEAT: begin
          if (w_req[k] != r_dir[k]) begin
            w_state_nxt[k] = S_IDLE;
          end else if (r_rcnt[k] == RP_LAST) begin
            w_pad_nxt[2*k +: 2] = r_dir[k];
            w_rcnt_nxt[k]       = 24'd0;
          end else begin
            w_rcnt_nxt[k] = r_rcnt[k] + 24'd1;
          end
        end
`else
        S_DELAY: begin
          if (w_req[k] != r_dir[k]) begin
            w_state_nxt[k] = S_IDLE;
          end else begin
            w_state_nxt[k] = S_DELAY;
          end
        end
`endif
        default: begin
          w_state_nxt[k] = S_IDLE;
        end
      endcase
    end
  end

  // Axis state registers and the registered step output.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      r_pad <= 12'h000;
      for (int k = 0; k < 6; k++) begin
        r_state[k] <= S_IDLE;
        r_dir[k]   <= 2'b00;
`ifdef CTRL_PAD_AUTOREPEAT_EN
        r_rcnt[k]  <= 24'd0;
`endif
      end
    end else begin
      r_pad <= w_pad_nxt;
      for (int k = 0; k < 6; k++) begin
        r_state[k] <= w_state_nxt[k];
        r_dir[k]   <= w_dir_nxt[k];
`ifdef CTRL_PAD_AUTOREPEAT_EN
        r_rcnt[k]  <= w_rcnt_nxt[k];
`endif
      end
    end
  end

  assign controlPad = r_pad;
  assign btn_db     = r_btn_db;

endmodule

// File: tb/tb_control_pad_encoder.sv
// Directed bench for control_pad_encoder with DEBOUNCE_CYC=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
// Expected pulse edges follow the auto-repeat setting selected by CTRL_PAD_AUTOREPEAT_EN.
module tb_control_pad_encoder;

  logic        fclk;
  logic        rst;
  logic [11:0] btn_raw;
  logic [11:0] controlPad;
  logic [11:0] btn_db;

  int n_chk;
  int n_fail;

  typedef struct packed {
    logic [11:0] btn;
    logic [11:0] pad;
    logic [11:0] db;
  } vec_t;

  vec_t vecs [16];

  control_pad_encoder #(
    .DEBOUNCE_CYC (4),
    .REPEAT_DELAY (20),
    .REPEAT_PERIOD(8)
  ) dut (
    .fclk      (fclk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .controlPad(controlPad),
    .btn_db    (btn_db)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Press stable after edge p, released after edge r: is a pulse due on edge e?
  function automatic bit pulse_at(input int e, input int p, input int r);
    if (e == p + 7) return 1'b1;
`ifdef CTRL_PAD_AUTOREPEAT_EN
    if (e >= p + 27 && e <= r + 6 && ((e - p - 27) % 8) == 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic do_reset();
    rst     = 1'b1;
    btn_raw = 12'h000;
    repeat (3) tick();
    chk("reset_pad", controlPad, 12'h000);
    chk("reset_db", btn_db, 12'h000);
    rst = 1'b0;
  endtask

  task automatic release_idle(input string nm);
    btn_raw = 12'h000;
    for (int n = 0; n < 12; n++) begin
      tick();
      chk(nm, controlPad, 12'h000);
    end
    chk({nm, "_db"}, btn_db, 12'h000);
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    rst     = 1'b1;
    btn_raw = 12'h000;

    vecs[0]  = '{12'h800, 12'h800, 12'h800};
    vecs[1]  = '{12'h400, 12'h400, 12'h400};
    vecs[2]  = '{12'h200, 12'h200, 12'h200};
    vecs[3]  = '{12'h100, 12'h100, 12'h100};
    vecs[4]  = '{12'h080, 12'h080, 12'h080};
    vecs[5]  = '{12'h040, 12'h040, 12'h040};
    vecs[6]  = '{12'h020, 12'h020, 12'h020};
    vecs[7]  = '{12'h010, 12'h010, 12'h010};
    vecs[8]  = '{12'h008, 12'h008, 12'h008};
    vecs[9]  = '{12'h004, 12'h004, 12'h004};
    vecs[10] = '{12'h002, 12'h002, 12'h002};
    vecs[11] = '{12'h001, 12'h001, 12'h001};
    vecs[12] = '{12'hAAA, 12'hAAA, 12'hAAA};
    vecs[13] = '{12'h555, 12'h555, 12'h555};
    vecs[14] = '{12'hC00, 12'h000, 12'hC00};
    vecs[15] = '{12'h600, 12'h600, 12'h600};

    // Single presses: pulse on edge 7 only, debounced level rises on edge 6.
    for (int v = 0; v < 16; v++) begin
      do_reset();
      btn_raw = vecs[v].btn;
      for (int e = 1; e <= 15; e++) begin
        tick();
        chk("vec_pad", controlPad, (e == 7) ? vecs[v].pad : 12'h000);
        if (e == 5) chk("vec_db_early", btn_db, 12'h000);
        if (e == 6) chk("vec_db", btn_db, vecs[v].db);
      end
      release_idle("vec_release");
    end

    // Fwd held 60 cycles: first pulse plus auto-repeats, none after release.
    do_reset();
    btn_raw = 12'h800;
    for (int e = 1; e <= 80; e++) begin
      tick();
      chk("fwd_hold", controlPad, pulse_at(e, 0, 60) ? 12'h800 : 12'h000);
      if (e == 60) btn_raw = 12'h000;
    end

    // Right bouncing every 2 cycles, then stable from edge 12.
    do_reset();
    btn_raw = 12'h100;
    for (int e = 1; e <= 30; e++) begin
      tick();
      chk("bounce", controlPad, pulse_at(e, 12, 30) ? 12'h100 : 12'h000);
      if (e <= 10 && (e % 2) == 0) btn_raw = btn_raw ^ 12'h100;
      if (e == 12) btn_raw = 12'h100;
    end
    release_idle("bounce_release");

    // Fwd+Back cancel out; releasing Back after edge 30 yields Fwd.
    do_reset();
    btn_raw = 12'hC00;
    for (int e = 1; e <= 45; e++) begin
      tick();
      chk("fwd_back", controlPad, pulse_at(e, 30, 999) ? 12'h800 : 12'h000);
      if (e == 30) btn_raw = 12'h800;
    end
    release_idle("fwd_back_release");

    // Reset asserted mid-hold right after a pulse, Down still held afterwards.
    do_reset();
    btn_raw = 12'h040;
    for (int e = 1; e <= 35; e++) begin
      tick();
      chk("down_hold", controlPad, pulse_at(e, 0, 999) ? 12'h040 : 12'h000);
    end
    rst = 1'b1;
    #1;
    chk("async_rst_pad", controlPad, 12'h000);
    chk("async_rst_db", btn_db, 12'h000);
    tick();
    tick();
    chk("rst_held_pad", controlPad, 12'h000);
    rst = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      tick();
      chk("post_rst", controlPad, pulse_at(e, 0, 999) ? 12'h040 : 12'h000);
    end
    release_idle("post_rst_release");

    // rotZ- held 100 cycles, released, pressed again after edge 120.
    do_reset();
    btn_raw = 12'h001;
    for (int e = 1; e <= 140; e++) begin
      tick();
      chk("rotz_hold", controlPad,
          (pulse_at(e, 0, 100) || pulse_at(e, 120, 999)) ? 12'h001 : 12'h000);
      if (e == 100) btn_raw = 12'h000;
      if (e == 120) btn_raw = 12'h001;
    end
    release_idle("rotz_release");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
